// File: rtl/trng_ctrl.sv
// trng_ctrl: sequencing and arbitration controller for the ring-oscillator TRNG.
//
// Discards WARMUP_BYTES assembled bytes after each enable, runs a repetition-count
// health test on every raw bit, assembles bytes MSB-first and hands each fresh byte
// to exactly one of NUM_REQ requesters, picked round-robin.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   enable       run request; low returns to IDLE (ignored in FAIL)
//   raw_bit      entropy bit from the ring oscillator
//   raw_valid    raw_bit is sampled this cycle
//   req          per-requester level request
//   clear_fail   acknowledges a health failure
//   gnt          one-hot, single-cycle grant
//   rnd_byte     last delivered byte, valid with gnt and held afterwards
//   byte_ready   a fresh byte is pending
//   health_fail  high while in FAIL
module trng_ctrl #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned WARMUP_BYTES = 4,
    parameter int unsigned REP_LIMIT    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               raw_bit,
    input  logic               raw_valid,
    input  logic [NUM_REQ-1:0] req,
    input  logic               clear_fail,
    output logic [NUM_REQ-1:0] gnt,
    output logic [7:0]         rnd_byte,
    output logic               byte_ready,
    output logic               health_fail
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWarmup,
        StCollect,
        StReady,
        StFail
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic [7:0]         run_q, run_d;
    logic               last_bit_q, last_bit_d;
    logic [7:0]         pend_byte_q, pend_byte_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [7:0]         rnd_byte_q, rnd_byte_d;
    logic               byte_ready_q, byte_ready_d;
    logic               health_fail_q, health_fail_d;

    logic               rep_hit;
    logic               shift_en;
    logic               byte_done;
    logic [7:0]         shreg_next;
    logic               found;
    logic [PtrW-1:0]    winner;
    logic [PtrW-1:0]    ptr_inc;

    // ------------------------------------------------------------------------
    // Repetition-count health test. Runs in every state except IDLE, including
    // FAIL, so a still-stuck source keeps the block in FAIL even if clear_fail
    // arrives in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        run_d      = run_q;
        last_bit_d = last_bit_q;
        rep_hit    = 1'b0;
        if (state_q == StIdle) begin
            run_d      = 8'd0;
            last_bit_d = 1'b0;
        end else if (raw_valid) begin
            last_bit_d = raw_bit;
            // run_q == 0 marks the first valid bit since IDLE
            if (run_q == 8'd0 || raw_bit != last_bit_q) begin
                run_d = 8'd1;
            end else if (run_q < 8'(REP_LIMIT)) begin
                run_d = run_q + 8'd1;
            end
            rep_hit = (run_d >= 8'(REP_LIMIT));
        end
    end

    // ------------------------------------------------------------------------
    // Byte assembly: only WARMUP and COLLECT shift; READY holds the pending byte
    // and lets raw bits pass through the health test only.
    // ------------------------------------------------------------------------
    assign shift_en   = raw_valid && (state_q == StWarmup || state_q == StCollect);
    assign byte_done  = shift_en && (bitcnt_q == 3'd7);
    assign shreg_next = {shreg_q[6:0], raw_bit};

    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        wcnt_d   = wcnt_q;
        if (state_q == StIdle || state_q == StFail) begin
            shreg_d  = 8'd0;
            bitcnt_d = 3'd0;
            wcnt_d   = 8'd0;
        end else if (shift_en) begin
            shreg_d  = shreg_next;
            bitcnt_d = bitcnt_q + 3'd1; // wraps 7 -> 0 on byte completion
            if (state_q == StWarmup && byte_done) begin
                wcnt_d = wcnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pick: first set req bit at ptr, ptr+1, ... modulo NUM_REQ.
    // ------------------------------------------------------------------------
    always_comb begin
        int unsigned idx;
        logic [PtrW-1:0] idx_p;
        idx    = 0;
        idx_p  = '0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx   = (32'(ptr_q) + i) % NUM_REQ;
            idx_p = PtrW'(idx);
            if (!found && req[idx_p]) begin
                found  = 1'b1;
                winner = idx_p;
            end
        end
    end

    assign ptr_inc = (winner == PtrW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    // ------------------------------------------------------------------------
    // State sequencing and registered outputs. A health hit outranks enable
    // low, byte completion and grants.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        rnd_byte_d  = rnd_byte_q;
        pend_byte_d = pend_byte_q;
        ptr_d       = ptr_q;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StWarmup;
                end
            end
            StWarmup: begin
                if (rep_hit) begin
                    state_d = StFail;
                end else if (!enable) begin
                    state_d = StIdle;
                end else if (byte_done && wcnt_q == 8'(WARMUP_BYTES - 1)) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (rep_hit) begin
                    state_d = StFail;
                end else if (!enable) begin
                    state_d = StIdle;
                end else if (byte_done) begin
                    pend_byte_d = shreg_next;
                    state_d     = StReady;
                end
            end
            StReady: begin
                if (rep_hit) begin
                    state_d = StFail;
                end else if (!enable) begin
                    state_d = StIdle;
                end else if (found) begin
                    gnt_d[winner] = 1'b1;
                    rnd_byte_d    = pend_byte_q;
                    ptr_d         = ptr_inc;
                    state_d       = StCollect;
                end
            end
            StFail: begin
                pend_byte_d = 8'd0;
                if (clear_fail && !rep_hit) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign byte_ready_d  = (state_d == StReady);
    assign health_fail_d = (state_d == StFail);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            shreg_q       <= 8'd0;
            bitcnt_q      <= 3'd0;
            wcnt_q        <= 8'd0;
            run_q         <= 8'd0;
            last_bit_q    <= 1'b0;
            pend_byte_q   <= 8'd0;
            ptr_q         <= '0;
            gnt_q         <= '0;
            rnd_byte_q    <= 8'd0;
            byte_ready_q  <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            wcnt_q        <= wcnt_d;
            run_q         <= run_d;
            last_bit_q    <= last_bit_d;
            pend_byte_q   <= pend_byte_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            rnd_byte_q    <= rnd_byte_d;
            byte_ready_q  <= byte_ready_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign gnt         = gnt_q;
    assign rnd_byte    = rnd_byte_q;
    assign byte_ready  = byte_ready_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// tb_trng_ctrl: directed self-checking bench for trng_ctrl
// (NUM_REQ=4, WARMUP_BYTES=2, REP_LIMIT=16).
module tb_trng_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       raw_bit;
    logic       raw_valid;
    logic [3:0] req;
    logic       clear_fail;
    logic [3:0] gnt;
    logic [7:0] rnd_byte;
    logic       byte_ready;
    logic       health_fail;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] gnt_log[$];
    logic [7:0] byte_log[$];

    trng_ctrl #(
        .NUM_REQ     (4),
        .WARMUP_BYTES(2),
        .REP_LIMIT   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .raw_bit    (raw_bit),
        .raw_valid  (raw_valid),
        .req        (req),
        .clear_fail (clear_fail),
        .gnt        (gnt),
        .rnd_byte   (rnd_byte),
        .byte_ready (byte_ready),
        .health_fail(health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every grant pulse with the byte delivered alongside it.
    always @(negedge clk) begin
        if (!reset && gnt != 4'd0) begin
            gnt_log.push_back(gnt);
            byte_log.push_back(rnd_byte);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_gnt(input int k);
        return (k < gnt_log.size()) ? 32'(gnt_log[k]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] log_byte(input int k);
        return (k < byte_log.size()) ? 32'(byte_log[k]) : 32'hDEAD;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed_bit(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        tick(1);
    endtask

    task automatic stop_bits();
        raw_valid = 1'b0;
        raw_bit   = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            feed_bit(b[i]);
        end
        stop_bits();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        req        = 4'd0;
        clear_fail = 1'b0;
        stop_bits();
        tick(2);
        reset = 1'b0;
        gnt_log.delete();
        byte_log.delete();
    endtask

    // Enable from IDLE and push the two warm-up bytes.
    task automatic start_and_warmup(input logic [7:0] w0, input logic [7:0] w1);
        enable = 1'b1;
        tick(1);
        feed_byte(w0);
        feed_byte(w1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Reset state ----------------
        do_reset();
        check_val("rst_gnt", 32'(gnt), 32'h0);
        check_val("rst_rnd", 32'(rnd_byte), 32'h0);
        check_val("rst_ready", 32'(byte_ready), 32'h0);
        check_val("rst_fail", 32'(health_fail), 32'h0);

        // ---------------- Warm-up and delivery ----------------
        req = 4'b0100;
        start_and_warmup(8'hAA, 8'hAA);
        check_val("wu_nogrant", 32'(gnt_log.size()), 32'd0);
        check_val("wu_ready_lo", 32'(byte_ready), 32'h0);
        feed_byte(8'hB2);
        check_val("dl_ready", 32'(byte_ready), 32'h1);
        tick(1);
        check_val("dl_gnt", 32'(gnt), 32'h4);
        check_val("dl_rnd", 32'(rnd_byte), 32'hB2);
        check_val("dl_ready_lo", 32'(byte_ready), 32'h0);
        tick(3);
        check_val("dl_once", 32'(gnt_log.size()), 32'd1);
        check_val("dl_hold", 32'(rnd_byte), 32'hB2);

        // ---------------- Round-robin fairness ----------------
        do_reset();
        start_and_warmup(8'hAA, 8'hAA);
        req = 4'b1011;
        feed_byte(8'h5A);
        tick(2);
        feed_byte(8'h3C);
        tick(2);
        feed_byte(8'hC3);
        tick(2);
        feed_byte(8'h96);
        tick(2);
        check_val("rr_count", 32'(gnt_log.size()), 32'd4);
        check_val("rr_g0", log_gnt(0), 32'h1);
        check_val("rr_g1", log_gnt(1), 32'h2);
        check_val("rr_g2", log_gnt(2), 32'h8);
        check_val("rr_g3", log_gnt(3), 32'h1);
        check_val("rr_b0", log_byte(0), 32'h5A);
        check_val("rr_b2", log_byte(2), 32'hC3);
        check_val("rr_b3", log_byte(3), 32'h96);
        // ptr should now be 1: next grant goes to requester 1
        feed_byte(8'hA5);
        tick(2);
        check_val("rr_ptr1", log_gnt(4), 32'h2);
        check_val("rr_ptr1_b", log_byte(4), 32'hA5);

        // ---------------- Health failure ----------------
        // FF in warm-up gives a run of 8 ones; 8 more in COLLECT reach 16,
        // coinciding with byte completion.
        do_reset();
        req = 4'b0001;
        start_and_warmup(8'hAA, 8'hFF);
        for (int i = 0; i < 7; i++) begin
            feed_bit(1'b1);
        end
        check_val("hf_15_ok", 32'(health_fail), 32'h0);
        feed_bit(1'b1);
        stop_bits();
        check_val("hf_16_fail", 32'(health_fail), 32'h1);
        check_val("hf_noready", 32'(byte_ready), 32'h0);
        tick(2);
        check_val("hf_nogrant", 32'(gnt_log.size()), 32'd0);
        enable = 1'b0;
        tick(3);
        check_val("hf_en_ignored", 32'(health_fail), 32'h1);
        // clear_fail with a fresh repeated bit in the same cycle: stay in FAIL
        clear_fail = 1'b1;
        feed_bit(1'b1);
        stop_bits();
        check_val("hf_clr_blocked", 32'(health_fail), 32'h1);
        tick(1);
        clear_fail = 1'b0;
        check_val("hf_cleared", 32'(health_fail), 32'h0);
        check_val("hf_cleared_gnt", 32'(gnt), 32'h0);

        // ---------------- Disable mid-byte ----------------
        do_reset();
        req = 4'b0001;
        start_and_warmup(8'hAA, 8'hAA);
        feed_bit(1'b1);
        feed_bit(1'b1);
        feed_bit(1'b1);
        feed_bit(1'b0);
        feed_bit(1'b0);
        stop_bits();
        enable = 1'b0;
        tick(1);
        start_and_warmup(8'hAA, 8'hAA);
        check_val("dis_wu_nogrant", 32'(gnt_log.size()), 32'd0);
        feed_byte(8'h3C);
        tick(2);
        check_val("dis_count", 32'(gnt_log.size()), 32'd1);
        check_val("dis_byte", log_byte(0), 32'h3C);
        check_val("dis_gnt", log_gnt(0), 32'h1);

        // ---------------- READY ignores bits ----------------
        do_reset();
        start_and_warmup(8'hAA, 8'hAA);
        feed_byte(8'hC5);
        check_val("rdy_ready", 32'(byte_ready), 32'h1);
        feed_byte(8'hAA);
        check_val("rdy_still", 32'(byte_ready), 32'h1);
        check_val("rdy_nogrant", 32'(gnt_log.size()), 32'd0);
        req = 4'b0010;
        tick(1);
        check_val("rdy_gnt", 32'(gnt), 32'h2);
        check_val("rdy_byte", 32'(rnd_byte), 32'hC5);
        req = 4'b0000;

        // ---------------- enable low in READY with req ----------------
        feed_byte(8'h0F);
        check_val("enl_ready", 32'(byte_ready), 32'h1);
        req    = 4'b0001;
        enable = 1'b0;
        tick(1);
        check_val("enl_nogrant", 32'(gnt), 32'h0);
        check_val("enl_ready_lo", 32'(byte_ready), 32'h0);
        check_val("enl_rnd_hold", 32'(rnd_byte), 32'hC5);

        // ---------------- Reset mid-grant ----------------
        // ptr is 2 here (retained across the disable); requester 1 wins next.
        req = 4'b0010;
        start_and_warmup(8'hAA, 8'hAA);
        feed_byte(8'h69);
        tick(1);
        check_val("rmg_pre_gnt", 32'(gnt), 32'h2);
        reset  = 1'b1;
        enable = 1'b0;
        req    = 4'b0000;
        tick(1);
        reset = 1'b0;
        check_val("rmg_gnt", 32'(gnt), 32'h0);
        check_val("rmg_rnd", 32'(rnd_byte), 32'h0);
        check_val("rmg_ready", 32'(byte_ready), 32'h0);
        check_val("rmg_fail", 32'(health_fail), 32'h0);
        // ptr back at 0: with every requester asserting, requester 0 wins
        req = 4'b1111;
        start_and_warmup(8'hAA, 8'hAA);
        check_val("rmg_wu_ready", 32'(byte_ready), 32'h0);
        feed_byte(8'h96);
        tick(1);
        check_val("rmg_ptr0", 32'(gnt), 32'h1);
        check_val("rmg_byte", 32'(rnd_byte), 32'h96);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
